// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the ALU datapath.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per step, WIDTH steps per load.
module mul_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH:0]     acc_sum;

    // Upper half accumulates the multiplicand; the multiplier drains out of the lower half.
    always_comb begin
        acc_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_d  = {acc_sum, prod_q[WIDTH-1:1]};
    end

    assign done    = (count_q == CNT_W'(WIDTH));
    assign product = prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else if (load) begin
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
            count_q <= '0;
        end else if (step && !done) begin
            prod_q  <= prod_d;
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_datapath.sv
// Execution datapath: captures an op on start, runs it in one cycle (ALU/shift) or WIDTH cycles (MUL),
// and returns a held result plus ZNCV/illegal flags with a one-cycle ready pulse.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             illegal_q;
    logic             ready_q;
    logic             busy_q;

    logic [WIDTH-1:0] alu_result_d;
    logic [3:0]       alu_flags_d;
    logic             alu_illegal_d;
    logic [WIDTH-1:0] flag_src;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   asr_w;
    logic [SH_W-1:0]  shamt;

    logic               mul_load;
    logic               mul_step;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign mul_load = (state_q == S_IDLE) && start && (op == OP_MUL);
    assign mul_step = (state_q == S_MUL);

    generate
        if (MUL_EN != 0) begin : g_mul
            mul_shift_add #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .load    (mul_load),
                .step    (mul_step),
                .a       (a_q_or_in(mul_load)),
                .b       (b_q_or_in(mul_load)),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // The multiplier loads on the same edge that captures the operands, so feed it the live inputs.
    function automatic logic [WIDTH-1:0] a_q_or_in(input logic sel);
        return sel ? a : a_q;
    endfunction

    function automatic logic [WIDTH-1:0] b_q_or_in(input logic sel);
        return sel ? b : b_q;
    endfunction

    // Shifts carry an extra guard bit so the last bit shifted out lands in a fixed position.
    always_comb begin
        shamt  = b_q[SH_W-1:0];
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        shl_w  = {1'b0, a_q} << shamt;
        shr_w  = {a_q, 1'b0} >> shamt;
        asr_w  = $signed({a_q, 1'b0}) >>> shamt;

        alu_result_d  = '0;
        alu_flags_d   = '0;
        alu_illegal_d = 1'b0;
        flag_src      = '0;

        case (op_q)
            OP_ADD: begin
                alu_result_d        = sum_w[WIDTH-1:0];
                alu_flags_d[FLAG_C] = sum_w[WIDTH];
                alu_flags_d[FLAG_V] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_result_d        = (op_q == OP_CMP) ? result_q : diff_w[WIDTH-1:0];
                alu_flags_d[FLAG_C] = diff_w[WIDTH];
                alu_flags_d[FLAG_V] = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_result_d = a_q & b_q;
            OP_OR:  alu_result_d = a_q | b_q;
            OP_XOR: alu_result_d = a_q ^ b_q;
            OP_SHL: begin
                alu_result_d        = shl_w[WIDTH-1:0];
                alu_flags_d[FLAG_C] = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_result_d        = shr_w[WIDTH:1];
                alu_flags_d[FLAG_C] = shr_w[0];
            end
            OP_ASR: begin
                alu_result_d        = asr_w[WIDTH:1];
                alu_flags_d[FLAG_C] = asr_w[0];
            end
            default: alu_illegal_d = 1'b1;
        endcase

        flag_src = (op_q == OP_CMP) ? diff_w[WIDTH-1:0] : alu_result_d;
        if (alu_illegal_d) begin
            alu_flags_d[FLAG_Z] = 1'b1;
        end else begin
            alu_flags_d[FLAG_Z] = (flag_src == '0);
            alu_flags_d[FLAG_N] = flag_src[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= (op == OP_MUL && MUL_EN != 0) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q  <= alu_result_d;
                    flags_q   <= alu_flags_d;
                    illegal_q <= alu_illegal_d;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                S_MUL: begin
                    if (mul_done) begin
                        result_q          <= mul_product[WIDTH-1:0];
                        flags_q[FLAG_Z]   <= (mul_product[WIDTH-1:0] == '0);
                        flags_q[FLAG_N]   <= mul_product[WIDTH-1];
                        flags_q[FLAG_C]   <= |mul_product[2*WIDTH-1:WIDTH];
                        flags_q[FLAG_V]   <= |mul_product[2*WIDTH-1:WIDTH];
                        illegal_q         <= 1'b0;
                        ready_q           <= 1'b1;
                        busy_q            <= 1'b0;
                        state_q           <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign result  = result_q;
    assign zero    = flags_q[FLAG_Z];
    assign neg     = flags_q[FLAG_N];
    assign carry   = flags_q[FLAG_C];
    assign ovf     = flags_q[FLAG_V];
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: latency, flags, busy handling, illegal ops and reset abort.
module tb_alu_datapath;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    // {op, a, b, result, z, n, c, v, illegal}
    localparam int NVEC = 13;
    logic [32:0] vec_tab [NVEC] = '{
        {4'h0, 8'h7F, 8'h01, 8'h80, 5'b01010},
        {4'h0, 8'hFF, 8'h01, 8'h00, 5'b10100},
        {4'h1, 8'h00, 8'h01, 8'hFF, 5'b01100},
        {4'h1, 8'h80, 8'h01, 8'h7F, 5'b00010},
        {4'h1, 8'h7F, 8'hFF, 8'h80, 5'b01110},
        {4'h2, 8'hF0, 8'h3C, 8'h30, 5'b00000},
        {4'h3, 8'hF0, 8'h0C, 8'hFC, 5'b01000},
        {4'h4, 8'hF0, 8'hF0, 8'h00, 5'b10000},
        {4'h5, 8'hA5, 8'h0B, 8'h28, 5'b00100},
        {4'h5, 8'h81, 8'h00, 8'h81, 5'b01000},
        {4'h6, 8'h81, 8'h01, 8'h40, 5'b00100},
        {4'h7, 8'h80, 8'h03, 8'hF0, 5'b01000},
        {4'h7, 8'h81, 8'h01, 8'hC0, 5'b01100}
    };

    alu_datapath #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .result  (result),
        .zero    (zero),
        .neg     (neg),
        .carry   (carry),
        .ovf     (ovf),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called #1 after an edge; returns #1 after the edge that sampled start.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, result, zero, neg, carry, ovf, illegal} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h",
                     {ready, busy, result, zero, neg, carry, ovf, illegal}, 14'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int cyc;
        issue(4'h0, 8'h7F, 8'h01);
        checks++;
        if ({busy, ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_busy got=%b exp=%b", {busy, ready}, 2'b10);
        end
        wait_ready(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL add_latency got=%0d exp=%0d", cyc, 1);
        end
        checks++;
        if ({busy, result, zero, neg, carry, ovf, illegal} !== {1'b0, 8'h80, 5'b01010}) begin
            errors++;
            $display("FAIL add_out got=%h exp=%h",
                     {busy, result, zero, neg, carry, ovf, illegal}, {1'b0, 8'h80, 5'b01010});
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL add_ready_pulse got=%b exp=%b", ready, 1'b0);
        end
    endtask

    task automatic test_alu_table();
        int cyc;
        for (int i = 0; i < NVEC; i++) begin
            issue(vec_tab[i][32:29], vec_tab[i][28:21], vec_tab[i][20:13]);
            wait_ready(cyc);
            checks++;
            if (cyc != 1) begin
                errors++;
                $display("FAIL table_latency[%0d] got=%0d exp=%0d", i, cyc, 1);
            end
            checks++;
            if ({result, zero, neg, carry, ovf, illegal} !== vec_tab[i][12:0]) begin
                errors++;
                $display("FAIL table_out[%0d] got=%h exp=%h", i,
                         {result, zero, neg, carry, ovf, illegal}, vec_tab[i][12:0]);
            end
        end
    endtask

    // SUB leaves 0xFF; CMP must not touch the result but updates flags from the difference.
    task automatic test_sub_cmp();
        int cyc;
        issue(4'h1, 8'h00, 8'h01);
        wait_ready(cyc);
        checks++;
        if ({result, zero, neg, carry, ovf, illegal} !== {8'hFF, 5'b01100}) begin
            errors++;
            $display("FAIL sub_out got=%h exp=%h", {result, zero, neg, carry, ovf, illegal}, {8'hFF, 5'b01100});
        end
        issue(4'h9, 8'h05, 8'h05);
        wait_ready(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL cmp_latency got=%0d exp=%0d", cyc, 1);
        end
        checks++;
        if ({result, zero, neg, carry, ovf, illegal} !== {8'hFF, 5'b10000}) begin
            errors++;
            $display("FAIL cmp_out got=%h exp=%h", {result, zero, neg, carry, ovf, illegal}, {8'hFF, 5'b10000});
        end
    endtask

    // Runs right after CMP, so the held result during the multiply is 0xFF.
    task automatic test_mul();
        int cyc;
        int busy_bad;
        int hold_bad;
        busy_bad = 0;
        hold_bad = 0;
        cyc = -1;
        issue(4'h8, 8'h10, 8'h11);
        if (busy !== 1'b1 || ready !== 1'b0) busy_bad++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                cyc = i;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (result !== 8'hFF || zero !== 1'b1) hold_bad++;
        end
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("FAIL mul_latency got=%0d exp=%0d", cyc, 9);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL mul_busy bad_cycles got=%0d exp=%0d", busy_bad, 0);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL mul_hold bad_cycles got=%0d exp=%0d", hold_bad, 0);
        end
        checks++;
        if ({busy, result, zero, neg, carry, ovf, illegal} !== {1'b0, 8'h10, 5'b00110}) begin
            errors++;
            $display("FAIL mul_out got=%h exp=%h",
                     {busy, result, zero, neg, carry, ovf, illegal}, {1'b0, 8'h10, 5'b00110});
        end
        issue(4'h8, 8'h0F, 8'h0F);
        wait_ready(cyc);
        checks++;
        if ({result, zero, neg, carry, ovf, illegal} !== {8'hE1, 5'b01000}) begin
            errors++;
            $display("FAIL mul_small got=%h exp=%h", {result, zero, neg, carry, ovf, illegal}, {8'hE1, 5'b01000});
        end
    endtask

    task automatic test_busy_ignore();
        int first_ready;
        int n_ready;
        first_ready = -1;
        n_ready     = 0;
        issue(4'h8, 8'h03, 8'h05);
        @(posedge clk);
        #1;
        issue(4'h0, 8'hAA, 8'h11);
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                n_ready++;
                if (first_ready < 0) first_ready = i;
            end
        end
        checks++;
        if (n_ready != 1 || first_ready != 9) begin
            errors++;
            $display("FAIL busy_ignore_ready got_count=%0d got_cycle=%0d exp_count=%0d exp_cycle=%0d",
                     n_ready, first_ready, 1, 9);
        end
        checks++;
        if ({result, zero, neg, carry, ovf, illegal} !== {8'h0F, 5'b00000}) begin
            errors++;
            $display("FAIL busy_ignore_out got=%h exp=%h", {result, zero, neg, carry, ovf, illegal}, {8'h0F, 5'b00000});
        end
    endtask

    task automatic test_illegal();
        int cyc;
        issue(4'hC, 8'h33, 8'h44);
        wait_ready(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL illegal_latency got=%0d exp=%0d", cyc, 1);
        end
        checks++;
        if ({result, zero, neg, carry, ovf, illegal} !== {8'h00, 5'b10001}) begin
            errors++;
            $display("FAIL illegal_out got=%h exp=%h", {result, zero, neg, carry, ovf, illegal}, {8'h00, 5'b10001});
        end
        issue(4'h0, 8'h01, 8'h01);
        wait_ready(cyc);
        checks++;
        if ({result, zero, neg, carry, ovf, illegal} !== {8'h02, 5'b00000}) begin
            errors++;
            $display("FAIL illegal_clear got=%h exp=%h", {result, zero, neg, carry, ovf, illegal}, {8'h02, 5'b00000});
        end
    endtask

    // Start issued in the same cycle as ready must be accepted.
    task automatic test_back_to_back();
        int cyc;
        issue(4'h0, 8'h01, 8'h02);
        wait_ready(cyc);
        checks++;
        if (result !== 8'h03) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=%h", result, 8'h03);
        end
        issue(4'h1, 8'h09, 8'h04);
        wait_ready(cyc);
        checks++;
        if (cyc != 1 || result !== 8'h05) begin
            errors++;
            $display("FAIL b2b_second got_cyc=%0d got=%h exp_cyc=%0d exp=%h", cyc, result, 1, 8'h05);
        end
    endtask

    task automatic test_reset_mid_mul();
        int n_ready;
        int cyc;
        n_ready = 0;
        issue(4'h8, 8'h07, 8'h09);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, result, zero, neg, carry, ovf, illegal} !== 14'h0) begin
            errors++;
            $display("FAIL rst_mid_mul_out got=%h exp=%h",
                     {ready, busy, result, zero, neg, carry, ovf, illegal}, 14'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (ready || busy) n_ready++;
        end
        checks++;
        if (n_ready != 0) begin
            errors++;
            $display("FAIL rst_mid_mul_quiet got=%0d exp=%0d", n_ready, 0);
        end
        issue(4'h0, 8'h02, 8'h03);
        wait_ready(cyc);
        checks++;
        if (cyc != 1 || {result, zero, neg, carry, ovf, illegal} !== {8'h05, 5'b00000}) begin
            errors++;
            $display("FAIL rst_then_add got_cyc=%0d got=%h exp_cyc=%0d exp=%h",
                     cyc, {result, zero, neg, carry, ovf, illegal}, 1, {8'h05, 5'b00000});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_table();
        test_sub_cmp();
        test_mul();
        test_busy_ignore();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
